// File: rtl/mux_bus_rr_arb_pkg.sv
// Shared types and helpers for the round-robin select generator that feeds the
// registered bus multiplexer.
package mux_bus_rr_arb_pkg;

    // Grant-state encodings.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Widest supported source count and the index width that covers it.
    localparam int unsigned MAX_INPUTS = 32;
    localparam int unsigned IDX_W      = 5;

    // Round-robin scan result.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // First requesting index after 'last', wrapping modulo n. The scan ends on
    // 'last' itself, so a sole requester can always be re-picked.
    function automatic rr_pick_t rr_pick(input logic [MAX_INPUTS-1:0] req,
                                         input logic [IDX_W-1:0]      last,
                                         input int unsigned           n);
        rr_pick_t    p;
        int unsigned idx;
        p = '0;
        for (int unsigned i = 1; i <= MAX_INPUTS; i++) begin
            if (i <= n && !p.found) begin
                idx = 32'(last) + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[IDX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = idx[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_bus_tag_pipe.sv
// Latency-matched {valid, tag} shift register. Its depth equals the register
// depth of the downstream mux so o_valid/o_tag line up with the mux Q output.
module mux_bus_tag_pipe
    import mux_bus_rr_arb_pkg::*;
#(
    parameter int unsigned C_LATENCY   = 1,
    parameter int unsigned C_TAG_WIDTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_aclr,
    input  logic                   i_ce,
    input  logic                   i_valid,
    input  logic [C_TAG_WIDTH-1:0] i_tag,
    output logic                   o_valid,
    output logic [C_TAG_WIDTH-1:0] o_tag
);

    logic [C_LATENCY-1:0]                  r_valid;
    logic [C_LATENCY-1:0][C_TAG_WIDTH-1:0] r_tag;

    // Shift one stage per enabled clock; reset flushes every in-flight word.
    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_valid <= '0;
            r_tag   <= '0;
        end else if (i_ce) begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            for (int i = 1; i < int'(C_LATENCY); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign o_valid = r_valid[C_LATENCY-1];
    assign o_tag   = r_tag[C_LATENCY-1];

endmodule

// File: rtl/mux_bus_rr_arb.sv
// Round-robin select generator for the registered bus mux: turns per-source
// requests into a registered select/enable/one-hot grant, with bounded bursts,
// a downstream stall and a valid/tag pipeline aligned to the mux output.
module mux_bus_rr_arb
    import mux_bus_rr_arb_pkg::*;
#(
    parameter int unsigned C_INPUTS    = 4,
    parameter int unsigned C_SEL_WIDTH = sel_width(C_INPUTS),
    parameter int unsigned C_LATENCY   = 1,
    parameter int unsigned C_BURST     = 1,
    parameter bit          C_HAS_CE    = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_aclr,
    input  logic                   i_ce,
    input  logic [C_INPUTS-1:0]    i_req,
    input  logic                   i_hold,
    output logic [C_SEL_WIDTH-1:0] o_s,
    output logic                   o_en,
    output logic [C_INPUTS-1:0]    o_gnt,
    output logic                   o_q_valid,
    output logic [C_SEL_WIDTH-1:0] o_q_tag
);

    localparam logic [IDX_W-1:0]       BURST_MAX = IDX_W'(C_BURST - 1);
    localparam logic [C_SEL_WIDTH-1:0] LAST_RST  = C_SEL_WIDTH'(C_INPUTS - 1);

    arb_state_e             r_state;
    logic [C_SEL_WIDTH-1:0] r_s;
    logic [C_SEL_WIDTH-1:0] r_last;
    logic [C_INPUTS-1:0]    r_gnt;
    logic [IDX_W-1:0]       r_bcnt;
    // Set while a burst may continue: cleared only when requests run dry, so a
    // HOLD stall resumes the burst in progress instead of rotating.
    logic                   r_burst_live;

    logic                   w_adv;
    logic [C_INPUTS-1:0]    w_s_onehot;
    logic                   w_req_s;
    logic                   w_others;
    logic                   w_burst_more;
    rr_pick_t               w_pick;

    assign w_adv        = i_ce || !C_HAS_CE;
    assign w_s_onehot   = C_INPUTS'(1) << r_s;
    assign w_req_s      = |(i_req & w_s_onehot);
    assign w_others     = |(i_req & ~w_s_onehot);
    assign w_burst_more = (r_bcnt < BURST_MAX);
    assign w_pick       = rr_pick(MAX_INPUTS'(i_req), IDX_W'(r_last), C_INPUTS);

    // Grant state machine: stall/idle, burst regrant, or rotate to candidate.
    always_ff @(posedge i_clk or posedge i_aclr) begin
        if (i_aclr) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_last       <= LAST_RST;
            r_gnt        <= '0;
            r_bcnt       <= '0;
            r_burst_live <= 1'b0;
        end else if (w_adv) begin
            if (i_hold || ~|i_req) begin
                r_state <= ST_IDLE;
                r_gnt   <= '0;
                if (!i_hold) begin
                    r_burst_live <= 1'b0;
                end
            end else if (r_burst_live && w_req_s && (w_burst_more || !w_others)) begin
                // Burst continues; a sole requester keeps the grant with BCNT saturated.
                r_state <= ST_GRANT;
                r_gnt   <= w_s_onehot;
                if (w_burst_more) begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end else if (w_pick.found) begin
                r_state      <= ST_GRANT;
                r_s          <= C_SEL_WIDTH'(w_pick.idx);
                r_last       <= C_SEL_WIDTH'(w_pick.idx);
                r_gnt        <= C_INPUTS'(1) << w_pick.idx;
                r_bcnt       <= '0;
                r_burst_live <= 1'b1;
            end
        end
    end

    assign o_s   = r_s;
    assign o_en  = (r_state == ST_GRANT);
    assign o_gnt = r_gnt;

    mux_bus_tag_pipe #(
        .C_LATENCY   (C_LATENCY),
        .C_TAG_WIDTH (C_SEL_WIDTH)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_aclr  (i_aclr),
        .i_ce    (w_adv),
        .i_valid (o_en),
        .i_tag   (r_s),
        .o_valid (o_q_valid),
        .o_tag   (o_q_tag)
    );

endmodule
